nms_controller: RTL and testbench

Non-maximum-suppression stage of the edge-detector pipeline. It keeps a 3-row window of gradient magnitudes and quantised gradient angles, 14 pixels wide. Each time the window anchor moves, a new row is shifted in and the 12 interior pixels of the centre row are evaluated one per cycle. A pixel's magnitude is kept if it is a local maximum along its gradient direction; otherwise it is replaced by 0.

---
 rtl/nms_controller.sv | 87 ++++++++
 tb/tb_nms_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nms_controller.sv
// Non-maximum suppression over a 3-row, 14-pixel gradient window.
// Each new row restarts a 12-cycle scan of the centre row's interior pixels.
module nms_controller (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 anchor_moving,
  input  logic [13:0][1:0]     gradient_angle,
  input  logic [13:0][7:0]     gradient_mag,
  output logic [11:0][7:0]     nms_grad_angle,
  output logic [11:0][7:0]     nms_out,
  output logic                 nms_final
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PROC = 1'b1;

  logic [0:0]          state;
  logic [3:0]          col;
  logic [13:0][7:0]    top_mag, mid_mag, bot_mag;
  logic [13:0][1:0]    top_ang, mid_ang, bot_ang;

  logic [3:0]          j;
  logic [7:0]          cen_mag, n1, n2, result;
  logic [1:0]          cen_ang;

  function automatic logic [7:0] suppress(input logic [7:0] m,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    return (m >= a && m >= b) ? m : 8'd0;
  endfunction

  // Output index col maps to window column col+1; neighbours follow the gradient direction.
  always_comb begin
    j       = col + 4'd1;
    cen_mag = mid_mag[j];
    cen_ang = mid_ang[j];
    n1      = 8'd0;
    n2      = 8'd0;
    case (cen_ang)
      2'd0: begin n1 = mid_mag[j - 4'd1]; n2 = mid_mag[j + 4'd1]; end
      2'd1: begin n1 = top_mag[j + 4'd1]; n2 = bot_mag[j - 4'd1]; end
      2'd2: begin n1 = top_mag[j];        n2 = bot_mag[j];        end
      default: begin n1 = top_mag[j - 4'd1]; n2 = bot_mag[j + 4'd1]; end
    endcase
    result = suppress(cen_mag, n1, n2);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state          <= IDLE;
      col            <= 4'd0;
      nms_final      <= 1'b0;
      nms_out        <= '0;
      nms_grad_angle <= '0;
      top_mag        <= '0;
      mid_mag        <= '0;
      bot_mag        <= '0;
      top_ang        <= '0;
      mid_ang        <= '0;
      bot_ang        <= '0;
    end else begin
      nms_final <= 1'b0;
      if (state == PROC) begin
        nms_out[col]        <= result;
        nms_grad_angle[col] <= {6'b0, cen_ang};
        if (col == 4'd11) begin
          nms_final <= 1'b1;
          state     <= IDLE;
        end else begin
          col <= col + 4'd1;
        end
      end
      // A strobe always wins over the scan bookkeeping above, even on the last column.
      if (anchor_moving) begin
        top_mag <= mid_mag;
        mid_mag <= bot_mag;
        bot_mag <= gradient_mag;
        top_ang <= mid_ang;
        mid_ang <= bot_ang;
        bot_ang <= gradient_angle;
        col     <= 4'd0;
        state   <= PROC;
      end
    end
  end

endmodule

// File: tb/tb_nms_controller.sv
// Scoreboard bench for nms_controller: directed rows, expected windows queued at strobe time.
module tb_nms_controller;

  typedef logic [11:0][7:0] vec_t;
  typedef struct {
    vec_t mag;
    vec_t ang;
  } exp_t;

  logic               tb_clk = 1'b0;
  logic               n_rst;
  logic               anchor_moving;
  logic [13:0][1:0]   gradient_angle;
  logic [13:0][7:0]   gradient_mag;
  logic [11:0][7:0]   nms_grad_angle;
  logic [11:0][7:0]   nms_out;
  logic               nms_final;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_strobe_cyc = 0;
  logic prev_final = 1'b0;

  nms_controller dut (
    .clk            (tb_clk),
    .n_rst          (n_rst),
    .anchor_moving  (anchor_moving),
    .gradient_angle (gradient_angle),
    .gradient_mag   (gradient_mag),
    .nms_grad_angle (nms_grad_angle),
    .nms_out        (nms_out),
    .nms_final      (nms_final)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  function automatic vec_t fill(input logic [7:0] v);
    vec_t r;
    for (int k = 0; k < 12; k++) r[k] = v;
    return r;
  endfunction

  function automatic logic [13:0][7:0] row_mag(input logic [7:0] v);
    logic [13:0][7:0] r;
    for (int c = 0; c < 14; c++) r[c] = v;
    return r;
  endfunction

  function automatic logic [13:0][1:0] row_ang(input logic [1:0] v);
    logic [13:0][1:0] r;
    for (int c = 0; c < 14; c++) r[c] = v;
    return r;
  endfunction

  task automatic push(input vec_t m, input vec_t a);
    exp_t e;
    e.mag = m;
    e.ang = a;
    sb.push_back(e);
  endtask

  task automatic strobe(input logic [13:0][7:0] m, input logic [13:0][1:0] a);
    @(negedge tb_clk);
    anchor_moving  = 1'b1;
    gradient_mag   = m;
    gradient_angle = a;
    @(posedge tb_clk);
    #1 last_strobe_cyc = cyc;
    @(negedge tb_clk);
    anchor_moving = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  // Monitor: every nms_final pops one expected window and checks latency and one-cycle width.
  always @(negedge tb_clk) begin
    if (prev_final) check("final_width", {95'b0, nms_final}, 96'd0);
    prev_final = (nms_final === 1'b1);
    if (nms_final === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_final", 96'd1, 96'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("nms_out", nms_out, e.mag);
        check("nms_grad_angle", nms_grad_angle, e.ang);
        check("latency", 96'(cyc - last_strobe_cyc), 96'd12);
      end
    end
  end

  initial begin
    logic [7:0]        ramp [10];
    logic [13:0][7:0]  m;
    vec_t              v;

    ramp = '{8'd0, 8'd51, 8'd102, 8'd153, 8'd204, 8'd255, 8'd204, 8'd153, 8'd102, 8'd51};
    n_rst          = 1'b0;
    anchor_moving  = 1'b0;
    gradient_mag   = '0;
    gradient_angle = '0;

    // Reset
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    n_rst = 1'b1;
    check("rst_out", nms_out, 96'd0);
    check("rst_ang", nms_grad_angle, 96'd0);
    check("rst_final", {95'b0, nms_final}, 96'd0);
    idle(3);
    check("rst_idle_final", {95'b0, nms_final}, 96'd0);

    // Vertical ramp, angle 2: only the 255 centre survives; first centre is the reset row
    for (int i = 0; i < 10; i++) begin
      push((i == 6) ? fill(8'd255) : fill(8'd0), (i == 0) ? fill(8'd0) : fill(8'd2));
      strobe(row_mag(ramp[i]), row_ang(2'd2));
      idle(14);
    end

    // Horizontal, angle 0: centre 51 (angle 2) first, then the alternating row
    for (int c = 0; c < 14; c++) m[c] = (c % 2 == 0) ? 8'd10 : 8'd200;
    push(fill(8'd0), fill(8'd2));
    strobe(m, row_ang(2'd0));
    idle(14);
    for (int k = 0; k < 12; k++) v[k] = (k % 2 == 0) ? 8'd200 : 8'd0;
    push(v, fill(8'd0));
    strobe(row_mag(8'd0), row_ang(2'd0));
    idle(14);

    // Diagonal, angle 1: top row has 150 at column 6
    m = row_mag(8'd50);
    m[6] = 8'd150;
    push(fill(8'd0), fill(8'd0));
    strobe(m, row_ang(2'd1));
    idle(14);
    v = fill(8'd0);
    v[5] = 8'd150;
    push(v, fill(8'd1));
    strobe(row_mag(8'd100), row_ang(2'd1));
    idle(14);
    v = fill(8'd100);
    v[4] = 8'd0;
    push(v, fill(8'd1));
    strobe(row_mag(8'd50), row_ang(2'd0));
    idle(14);

    // Restart: second strobe mid-scan; only one result, for the doubly shifted window
    strobe(row_mag(8'd77), row_ang(2'd2));
    idle(4);
    push(fill(8'd77), fill(8'd2));
    strobe(row_mag(8'd0), row_ang(2'd0));
    idle(16);

    // Reset mid-scan: no pulse, everything cleared
    strobe(row_mag(8'd9), row_ang(2'd3));
    idle(5);
    n_rst = 1'b0;
    @(negedge tb_clk);
    n_rst = 1'b1;
    idle(20);
    check("midrst_out", nms_out, 96'd0);
    check("midrst_ang", nms_grad_angle, 96'd0);
    check("sb_empty", 96'(sb.size()), 96'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
